fetch_controller: RTL and testbench

//  Drives the program counter register: computes next PC and its write strobe.

---
 rtl/fetch_controller_if.sv | 26 ++
 rtl/fetch_controller.sv | 153 +++++++++++++++
 tb/tb_fetch_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Instruction memory read port shared between the fetch controller and memory.
// The controller is the master: it drives the request level and address,
// memory answers with ack and data in the same or a later request cycle.
interface fetch_controller_if #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 16
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch controller: drives the PC register (PC_next/PC_write), fetches one
// instruction per request/ack handshake and holds it with its PC for decode.
// Handles decode stall and branch redirect (branch flushes the held slot).
// Optional feature macro FETCH_PERF_EN adds fetch_count / stall_count ports.
module fetch_controller #(
    parameter int unsigned N            = 16,
    parameter int unsigned W            = 16,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned STEP         = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [N-1:0]        PC_cur,
    output logic [N-1:0]        PC_next,
    output logic                PC_write,
    fetch_controller_if.master  imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [N-1:0]        branch_target,
    output logic [W-1:0]        instr,
    output logic [N-1:0]        instr_pc,
    output logic                instr_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [N-1:0] RESET_PC = N'(RESET_VECTOR);
    localparam logic [N-1:0] STEP_N   = N'(STEP);

    state_t       state_q, state_d;
    logic [W-1:0] instr_q, instr_d;
    logic [N-1:0] instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;

    logic [N-1:0] pc_next;
    logic         pc_write;
    logic         req;
    logic         accept;

    // Next-state, PC update and memory request; branch wins over fetch accept.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_next       = PC_cur;
        pc_write      = 1'b0;
        req           = 1'b0;
        accept        = 1'b0;

        unique case (state_q)
            BOOT: begin
                pc_write = 1'b1;
                pc_next  = RESET_PC;
                state_d  = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    // Redirect: request dropped, any ack this cycle is ignored.
                    pc_write      = 1'b1;
                    pc_next       = branch_target;
                    instr_valid_d = 1'b0;
                end else if (instr_valid_q && stall) begin
                    state_d = HOLD;
                end else begin
                    req = 1'b1;
                    if (imem.imem_ack) begin
                        accept        = 1'b1;
                        pc_write      = 1'b1;
                        pc_next       = PC_cur + STEP_N;
                        instr_d       = imem.imem_data;
                        instr_pc_d    = PC_cur;
                        instr_valid_d = 1'b1;
                    end else if (!stall) begin
                        instr_valid_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_write      = 1'b1;
                    pc_next       = branch_target;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign PC_next        = pc_next;
    assign PC_write       = pc_write;
    assign imem.imem_req  = req;
    assign imem.imem_addr = PC_cur;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = instr_valid_q;

    // State and held-instruction registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q       <= BOOT;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters wrap naturally at 2^32; branch-discarded acks never set accept.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(accept);
        stall_count_d = stall_count_q + 32'(instr_valid_q && stall);
    end

    // Performance counter registers.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a hand-written reset/boot
// sequence followed by a table of per-cycle vectors with hand-computed
// expectations. The bench models the external PC register.
module tb_fetch_controller;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] PC_cur;
    logic [15:0] PC_next;
    logic        PC_write;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic        pc_ovr;
    logic [15:0] pc_ovr_val;

    int checks;
    int failures;

    fetch_controller_if #(.N(16), .W(16)) imem_bus ();

    fetch_controller #(
        .N(16), .W(16), .RESET_VECTOR(0), .STEP(1)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .PC_cur       (PC_cur),
        .PC_next      (PC_next),
        .PC_write     (PC_write),
        .imem         (imem_bus),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // External PC register; the override lets the bench preset a value.
    always @(posedge Clock) begin
        if (pc_ovr)
            PC_cur <= pc_ovr_val;
        else if (PC_write)
            PC_cur <= PC_next;
    end

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        ack;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] data;
        logic        e_pcw;
        logic [15:0] e_pcn;
        logic        e_req;
        logic        e_valid;
        logic [15:0] e_ipc;
        logic [15:0] e_instr;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic rst_n, input logic stl, input logic ack, input logic br,
        input logic [15:0] tgt, input logic [15:0] data,
        input logic pcw, input logic [15:0] pcn, input logic req,
        input logic valid, input logic [15:0] ipc, input logic [15:0] ins);
        vec_t v;
        v.rst_n = rst_n; v.stall = stl; v.ack = ack; v.br = br;
        v.tgt = tgt; v.data = data; v.e_pcw = pcw; v.e_pcn = pcn;
        v.e_req = req; v.e_valid = valid; v.e_ipc = ipc; v.e_instr = ins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic pcw, input logic [15:0] pcn,
                              input logic req, input logic valid);
        chk({tag, ".PC_write"}, 32'(PC_write), 32'(pcw));
        chk({tag, ".PC_next"}, 32'(PC_next), 32'(pcn));
        chk({tag, ".imem_req"}, 32'(imem_bus.imem_req), 32'(req));
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(valid));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Rows: rst_n stall ack br tgt data | PC_write PC_next req valid instr_pc instr
        vecs[0]  = mk(1,0,1,0,16'h0000,16'hA000, 1,16'h0001,1,0,16'h0000,16'h0000);
        vecs[1]  = mk(1,0,1,0,16'h0000,16'hA001, 1,16'h0002,1,1,16'h0000,16'hA000);
        vecs[2]  = mk(1,0,1,0,16'h0000,16'hA002, 1,16'h0003,1,1,16'h0001,16'hA001);
        vecs[3]  = mk(1,0,1,0,16'h0000,16'hA003, 1,16'h0004,1,1,16'h0002,16'hA002);
        vecs[4]  = mk(1,0,1,0,16'h0000,16'hA004, 1,16'h0005,1,1,16'h0003,16'hA003);
        vecs[5]  = mk(1,0,1,0,16'h0000,16'hA005, 1,16'h0006,1,1,16'h0004,16'hA004);
        // Stall four cycles on the instruction at pc 5.
        vecs[6]  = mk(1,1,0,0,16'h0000,16'h0000, 0,16'h0006,0,1,16'h0005,16'hA005);
        vecs[7]  = mk(1,1,0,0,16'h0000,16'h0000, 0,16'h0006,0,1,16'h0005,16'hA005);
        vecs[8]  = mk(1,1,0,0,16'h0000,16'h0000, 0,16'h0006,0,1,16'h0005,16'hA005);
        vecs[9]  = mk(1,1,0,0,16'h0000,16'h0000, 0,16'h0006,0,1,16'h0005,16'hA005);
        vecs[10] = mk(1,0,0,0,16'h0000,16'h0000, 0,16'h0006,0,1,16'h0005,16'hA005);
        vecs[11] = mk(1,0,1,0,16'h0000,16'hA006, 1,16'h0007,1,0,16'h0000,16'h0000);
        vecs[12] = mk(1,0,0,0,16'h0000,16'h0000, 0,16'h0007,1,1,16'h0006,16'hA006);
        vecs[13] = mk(1,0,1,0,16'h0000,16'hA007, 1,16'h0008,1,0,16'h0000,16'h0000);
        // Branch with simultaneous ack while stalled: data dropped, slot flushed.
        vecs[14] = mk(1,1,1,1,16'h0040,16'hBEEF, 1,16'h0040,0,1,16'h0007,16'hA007);
        vecs[15] = mk(1,0,1,0,16'h0000,16'hA040, 1,16'h0041,1,0,16'h0000,16'h0000);
        vecs[16] = mk(1,0,0,0,16'h0000,16'h0000, 0,16'h0041,1,1,16'h0040,16'hA040);
        vecs[17] = mk(1,0,1,0,16'h0000,16'hA041, 1,16'h0042,1,0,16'h0000,16'h0000);
        // Stall into HOLD, then branch from HOLD to 0xFFFF.
        vecs[18] = mk(1,1,0,0,16'h0000,16'h0000, 0,16'h0042,0,1,16'h0041,16'hA041);
        vecs[19] = mk(1,1,0,1,16'hFFFF,16'h0000, 1,16'hFFFF,0,1,16'h0041,16'hA041);
        // PC wrap.
        vecs[20] = mk(1,0,1,0,16'h0000,16'hCAFE, 1,16'h0000,1,0,16'h0000,16'h0000);
        vecs[21] = mk(1,0,1,0,16'h0000,16'hA000, 1,16'h0001,1,1,16'hFFFF,16'hCAFE);
        // Reset while requesting with a valid instruction held.
        vecs[22] = mk(0,0,0,0,16'h0000,16'h0000, 0,16'h0001,1,1,16'h0000,16'hA000);
        vecs[23] = mk(1,0,0,0,16'h0000,16'h0000, 1,16'h0000,0,0,16'h0000,16'h0000);

        // Reset held three cycles with the PC register preset to 0x1234.
        Reset_n            = 1'b0;
        pc_ovr             = 1'b1;
        pc_ovr_val         = 16'h1234;
        PC_cur             = 16'h1234;
        stall              = 1'b0;
        branch_taken       = 1'b0;
        branch_target      = '0;
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = '0;
        @(posedge Clock); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            chk("rst.imem_req", 32'(imem_bus.imem_req), 32'd0);
            chk("rst.instr_valid", 32'(instr_valid), 32'd0);
            @(posedge Clock); #1;
        end

        // First cycle after release is BOOT.
        Reset_n = 1'b1;
        pc_ovr  = 1'b0;
        @(negedge Clock);
        check_outs("boot", 1'b1, 16'h0000, 1'b0, 1'b0);
        chk("boot.instr_pc", 32'(instr_pc), 32'h0);
        chk("boot.instr", 32'(instr), 32'h0);
        chk("boot.imem_addr", 32'(imem_bus.imem_addr), 32'h1234);
        @(posedge Clock); #1;

        for (int i = 0; i < NV; i++) begin
            Reset_n            = vecs[i].rst_n;
            stall              = vecs[i].stall;
            imem_bus.imem_ack  = vecs[i].ack;
            branch_taken       = vecs[i].br;
            branch_target      = vecs[i].tgt;
            imem_bus.imem_data = vecs[i].data;
            @(negedge Clock);
            check_outs($sformatf("vec%0d", i), vecs[i].e_pcw, vecs[i].e_pcn,
                       vecs[i].e_req, vecs[i].e_valid);
            chk($sformatf("vec%0d.imem_addr", i), 32'(imem_bus.imem_addr), 32'(PC_cur));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d.instr_pc", i), 32'(instr_pc), 32'(vecs[i].e_ipc));
                chk($sformatf("vec%0d.instr", i), 32'(instr), 32'(vecs[i].e_instr));
            end
`ifdef FETCH_PERF_EN
            if (i == 21) begin
                chk("perf.fetch_count", fetch_count, 32'd11);
                chk("perf.stall_count", stall_count, 32'd7);
            end
            if (i == 23) begin
                chk("perf.fetch_count_rst", fetch_count, 32'd0);
                chk("perf.stall_count_rst", stall_count, 32'd0);
            end
`endif
            @(posedge Clock); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
